// File: rtl/sample_issue.sv
// rtl/sample_issue.sv - frame-based I/Q sample issuer with 2-entry skid buffer and issue pacing
// Feeds one FRAME_LEN-sample frame per start to the sample fetcher, honouring stop_in backpressure.
module sample_issue #(
    parameter int S_WIDTH   = 24,
    parameter int FRAME_LEN = 29,
    parameter int PACE      = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [S_WIDTH-1:0]             in_i,
    input  logic [S_WIDTH-1:0]             in_q,
    input  logic                           stop_in,
    output logic                           incoming,
    output logic [S_WIDTH-1:0]             samp_i,
    output logic [S_WIDTH-1:0]             samp_q,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(FRAME_LEN+1)-1:0] sent_count
);

    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam int PW = (PACE > 1) ? $clog2(PACE) : 1;
    localparam logic [CW-1:0] LAST_IDX  = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_LEN);
    localparam logic [PW-1:0] PACE_RELOAD = PW'(PACE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [S_WIDTH-1:0] buf_i_q [2];
    logic [S_WIDTH-1:0] buf_q_q [2];
    logic               rd_ptr_q, wr_ptr_q;
    logic [1:0]         cnt_q, cnt_d;
    logic [CW-1:0]      acc_q, acc_d;
    logic [CW-1:0]      sent_q, sent_d;
    logic [PW-1:0]      pace_q, pace_d;
    logic [S_WIDTH-1:0] last_i_q, last_q_q;

    logic accept;
    logic issue;

    // Gated by reset so nothing is pushed or accepted in the reset cycle itself.
    assign in_ready = (state_q == ST_ISSUE) && (cnt_q != 2'd2) && (acc_q < FRAME_CNT) && !reset;
    assign issue    = (state_q == ST_ISSUE) && (cnt_q != 2'd0) && (pace_q == '0) && !stop_in && !reset;
    assign accept   = in_valid && in_ready;
    assign incoming = issue;

    // An empty buffer shows the last issued sample so the output holds between frames.
    assign samp_i     = (cnt_q != 2'd0) ? buf_i_q[rd_ptr_q] : last_i_q;
    assign samp_q     = (cnt_q != 2'd0) ? buf_q_q[rd_ptr_q] : last_q_q;
    assign sent_count = sent_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sent_d  = sent_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    acc_d   = '0;
                    sent_d  = '0;
                end
            end
            ST_ISSUE: begin
                busy = 1'b1;
                if (accept) begin
                    acc_d = acc_q + CW'(1);
                end
                if (issue) begin
                    sent_d = sent_q + CW'(1);
                    if (sent_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({accept, issue})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        pace_d = pace_q;
        if (issue) begin
            pace_d = PACE_RELOAD;
        end else if (pace_q != '0) begin
            pace_d = pace_q - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            acc_q    <= '0;
            sent_q   <= '0;
            pace_q   <= '0;
            last_i_q <= '0;
            last_q_q <= '0;
            for (int k = 0; k < 2; k++) begin
                buf_i_q[k] <= '0;
                buf_q_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sent_q  <= sent_d;
            pace_q  <= pace_d;
            if (accept) begin
                buf_i_q[wr_ptr_q] <= in_i;
                buf_q_q[wr_ptr_q] <= in_q;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (issue) begin
                last_i_q <= buf_i_q[rd_ptr_q];
                last_q_q <= buf_q_q[rd_ptr_q];
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_sample_issue.sv
// tb/tb_sample_issue.sv - randomized bench for sample_issue against a frame-level reference model
// Two instances (short frame back-to-back, long frame paced) share one stimulus stream.
module tb_sample_issue;

    localparam int SW = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, in_valid, stop_in;
    logic [SW-1:0] in_i, in_q;

    logic          rdy_a, inc_a, busy_a, done_a;
    logic [SW-1:0] si_a, sq_a;
    logic [2:0]    sc_a;
    logic          rdy_b, inc_b, busy_b, done_b;
    logic [SW-1:0] si_b, sq_b;
    logic [4:0]    sc_b;

    sample_issue #(.S_WIDTH(SW), .FRAME_LEN(4), .PACE(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy_a),
        .in_i(in_i), .in_q(in_q), .stop_in(stop_in), .incoming(inc_a),
        .samp_i(si_a), .samp_q(sq_a), .busy(busy_a), .done(done_a), .sent_count(sc_a)
    );

    sample_issue #(.S_WIDTH(SW), .FRAME_LEN(29), .PACE(3)) dut_b (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy_b),
        .in_i(in_i), .in_q(in_q), .stop_in(stop_in), .incoming(inc_b),
        .samp_i(si_b), .samp_q(sq_b), .busy(busy_b), .done(done_b), .sent_count(sc_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: a frame is a list of accepted samples; entries in flight = accepted - issued.
    int          fl [2];
    int          pc [2];
    int          ph [2];
    int          acc [2];
    int          snt [2];
    int          gap [2];
    logic [47:0] lst [2][64];
    logic [47:0] last [2];
    bit          e_rdy [2];
    bit          e_inc [2];
    bit          model_ok;

    initial begin
        fl[0] = 4;  pc[0] = 1;
        fl[1] = 29; pc[1] = 3;
        model_ok = 1'b0;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; stop_in = 1'b0;
        in_i = '0; in_q = '0;

        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                logic [47:0] e_samp;
                logic [47:0] o_samp;
                bit          o_rdy, o_inc, o_busy, o_done;
                int          o_sc;
                if (reset) begin
                    e_rdy[d] = 1'b0;
                    e_inc[d] = 1'b0;
                end else begin
                    e_rdy[d] = (ph[d] == 1) && ((acc[d] - snt[d]) < 2) && (acc[d] < fl[d]);
                    e_inc[d] = (ph[d] == 1) && (acc[d] > snt[d]) && (gap[d] >= pc[d]) && !stop_in;
                end
                e_samp = (acc[d] > snt[d]) ? lst[d][snt[d]] : last[d];
                o_rdy  = (d == 0) ? rdy_a : rdy_b;
                o_inc  = (d == 0) ? inc_a : inc_b;
                o_busy = (d == 0) ? busy_a : busy_b;
                o_done = (d == 0) ? done_a : done_b;
                o_samp = (d == 0) ? {si_a, sq_a} : {si_b, sq_b};
                o_sc   = (d == 0) ? int'(sc_a) : int'(sc_b);
                if (model_ok) begin
                    check($sformatf("in_ready%0d", d), 64'(o_rdy), 64'(e_rdy[d]));
                    check($sformatf("incoming%0d", d), 64'(o_inc), 64'(e_inc[d]));
                    if (!reset) begin
                        check($sformatf("samp%0d", d), 64'(o_samp), 64'(e_samp));
                        check($sformatf("busy%0d", d), 64'(o_busy), 64'(ph[d] == 1));
                        check($sformatf("done%0d", d), 64'(o_done), 64'(ph[d] == 2));
                        check($sformatf("sent_count%0d", d), 64'(o_sc), 64'(snt[d]));
                    end
                end
            end

            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                if (reset) begin
                    ph[d] = 0; acc[d] = 0; snt[d] = 0; gap[d] = 1000; last[d] = '0;
                end else begin
                    if (e_inc[d]) gap[d] = 1;
                    else if (gap[d] < 1000) gap[d] = gap[d] + 1;
                    if (e_inc[d]) begin
                        last[d] = lst[d][snt[d]];
                        snt[d]  = snt[d] + 1;
                    end
                    if (e_rdy[d] && in_valid) begin
                        lst[d][acc[d]] = {in_i, in_q};
                        acc[d] = acc[d] + 1;
                    end
                    case (ph[d])
                        0: if (start) begin ph[d] = 1; acc[d] = 0; snt[d] = 0; end
                        1: if (e_inc[d] && snt[d] == fl[d]) ph[d] = 2;
                        default: ph[d] = 0;
                    endcase
                end
            end
            if (reset) model_ok = 1'b1;

            #1;
            if (cyc < 3) begin
                reset = 1'b1; start = 1'b0; in_valid = 1'b0; stop_in = 1'b0;
            end else if (cyc < 60) begin
                // Plain frame: constant valid, no backpressure, counting data.
                reset    = 1'b0;
                start    = (cyc == 4) || (cyc == 20);
                in_valid = 1'b1;
                stop_in  = 1'b0;
                in_i     = SW'(cyc);
                in_q     = SW'(cyc * 3);
            end else if (cyc < 1500) begin
                reset    = 1'b0;
                start    = ($urandom % 8) == 0;
                in_valid = 1'b1;
                stop_in  = ($urandom % 4) == 0;
                in_i     = SW'($urandom);
                in_q     = SW'($urandom);
            end else if (cyc < 3000) begin
                reset    = 1'b0;
                start    = ($urandom % 8) == 0;
                in_valid = cyc[0];
                stop_in  = ($urandom % 5) == 0;
                in_i     = SW'($urandom);
                in_q     = SW'($urandom);
            end else begin
                reset    = ($urandom % 150) == 0;
                start    = ($urandom % 6) == 0;
                in_valid = ($urandom % 2) == 0;
                stop_in  = ($urandom % 3) == 0;
                in_i     = SW'($urandom);
                in_q     = SW'($urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
